// File: rtl/fifo_wptr_full_pkg.sv
// fifo_wptr_full_pkg: pointer width and full-compare helper shared by the FIFO write and read status blocks.
package fifo_wptr_full_pkg;
   function automatic int ptr_w(input int aw);
      return aw + 1;
   endfunction
   // Full when the Gray pointers differ in exactly their top two bits (one lap apart).
   function automatic logic ptr_full(input logic [31:0] wg, input logic [31:0] rg, input int aw);
      logic [31:0] mask;
      logic [31:0] flip;
      mask = (32'd1 << (aw + 1)) - 32'd1;
      flip = 32'd3 << (aw - 1);
      return ((wg ^ rg ^ flip) & mask) == 32'd0;
   endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: binary to reflected Gray code conversion.
module bin2gray #(
   parameter int DW = 5
) (
   input  logic [DW-1:0] bin_i,
   output logic [DW-1:0] gray_o
);
   assign gray_o = bin_i ^ (bin_i >> 1);
endmodule

// File: rtl/gray2bin.sv
// gray2bin: reflected Gray code to binary; each bit is the XOR of all Gray bits at or above it.
module gray2bin #(
   parameter int DW = 5
) (
   input  logic [DW-1:0] gray_i,
   output logic [DW-1:0] bin_o
);
   always_comb begin
      bin_o = '0;
      for (int i = 0; i < DW; i++) bin_o[i] = ^(gray_i >> i);
   end
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer of a dual-clock FIFO with full, almost-full, fill level and overflow status.
module fifo_wptr_full
   import fifo_wptr_full_pkg::*;
#(
   parameter int AW        = 4,
   parameter int AFULL_GAP = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [ptr_w(AW)-1:0]    rptr_gray_sync,
   output logic [AW-1:0]           wr_addr,
   output logic [ptr_w(AW)-1:0]    wptr_gray,
   output logic                    full,
   output logic                    almost_full,
   output logic [ptr_w(AW)-1:0]    wr_count,
   output logic                    overflow
);
   localparam int PW = ptr_w(AW);
   localparam logic [PW-1:0] DEPTH = PW'(1) << AW;
   logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, cnt_q, cnt_d, rbin, free;
   logic          full_q, full_d, afull_q, afull_d, ovf_q, ovf_d, accept;
   bin2gray #(.DW(PW)) u_b2g (.bin_i(wbin_d), .gray_o(wgray_d));
   gray2bin #(.DW(PW)) u_g2b (.gray_i(rptr_gray_sync), .bin_o(rbin));
   always_comb begin
      accept  = wr_en & ~full_q;
      wbin_d  = wbin_q + PW'(accept);
      cnt_d   = wbin_d - rbin;
      free    = DEPTH - cnt_d;
      afull_d = free <= PW'(AFULL_GAP);
      full_d  = ptr_full(32'(wgray_d), 32'(rptr_gray_sync), AW);
      ovf_d   = wr_en & full_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         afull_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end
   assign wr_addr     = wbin_q[AW-1:0];
   assign wptr_gray   = wgray_q;
   assign full        = full_q;
   assign almost_full = afull_q;
   assign wr_count    = cnt_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scoreboard bench for the FIFO write pointer block at AW=3, AFULL_GAP=2.
module tb_fifo_wptr_full;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] rptr_gray_sync = '0;
   logic [2:0] wr_addr;
   logic [3:0] wptr_gray;
   logic       full, almost_full, overflow;
   logic [3:0] wr_count;
   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0] addr;
      logic [3:0] gray;
      logic       full;
      logic       afull;
      logic [3:0] cnt;
      logic       ovf;
   } exp_t;
   exp_t sb[$];

   int m_wb = 0;
   logic m_full = 1'b0;

   fifo_wptr_full #(.AW(3), .AFULL_GAP(2)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .rptr_gray_sync(rptr_gray_sync),
      .wr_addr(wr_addr), .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
      .wr_count(wr_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] to_gray(input int b);
      logic [3:0] v;
      v = 4'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int from_gray(input logic [3:0] g);
      int b;
      b = 0;
      for (int i = 3; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
      return b;
   endfunction

   task automatic step(input logic we, input logic [3:0] rg);
      int nb, cnt;
      logic acc;
      exp_t e, o;
      wr_en = we;
      rptr_gray_sync = rg;
      acc = we & ~m_full;
      nb = (m_wb + int'(acc)) & 15;
      cnt = (nb - from_gray(rg)) & 15;
      e.addr = 3'(nb);
      e.gray = to_gray(nb);
      e.full = (cnt == 8);
      e.afull = ((8 - cnt) <= 2);
      e.cnt = 4'(cnt);
      e.ovf = we & m_full;
      sb.push_back(e);
      m_wb = nb;
      m_full = e.full;
      @(posedge clk);
      #1;
      o = sb.pop_front();
      chk("wr_addr", 32'(wr_addr), 32'(o.addr));
      chk("wptr_gray", 32'(wptr_gray), 32'(o.gray));
      chk("full", 32'(full), 32'(o.full));
      chk("almost_full", 32'(almost_full), 32'(o.afull));
      chk("wr_count", 32'(wr_count), 32'(o.cnt));
      chk("overflow", 32'(overflow), 32'(o.ovf));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, 32'(wr_addr), 0);
      chk({tag, "_gray"}, 32'(wptr_gray), 0);
      chk({tag, "_full"}, 32'(full), 0);
      chk({tag, "_afull"}, 32'(almost_full), 0);
      chk({tag, "_cnt"}, 32'(wr_count), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
   endtask

   initial begin
      logic [3:0] gtab [8];
      logic [3:0] prev;
      int wraps;
      gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      repeat (2) @(posedge clk);
      #1;
      chk_zero("in_reset");
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b0, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 4'b0000);
         chk("gray_table", 32'(wptr_gray), 32'(gtab[i]));
         chk("afull_edge", 32'(almost_full), 32'(i >= 5));
         chk("full_edge", 32'(full), 32'(i == 7));
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'b0000);
         chk("ovf_hold", 32'(overflow), 1);
      end
      step(1'b0, 4'b0000);
      step(1'b0, 4'b0010);
      chk("jump_cnt", 32'(wr_count), 5);
      step(1'b1, 4'b0010);
      chk("jump_afull", 32'(almost_full), 1);
      wraps = 0;
      prev = wptr_gray;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, to_gray((m_wb - 2) & 15));
         chk("one_bit", $countones(prev ^ wptr_gray), 1);
         chk("never_full", 32'(full), 0);
         if (prev == 4'b1000 && wptr_gray == 4'b0000) wraps++;
         prev = wptr_gray;
      end
      chk("wrapped", 32'(wraps > 0), 1);
      step(1'b0, to_gray(m_wb));
      for (int i = 0; i < 5; i++) step(1'b1, rptr_gray_sync);
      chk("pre_reset_cnt", 32'(wr_count), 5);
      wr_en = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_zero("mid_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_wb = 0;
      m_full = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 4'b0000);
      chk("resume_cnt", 32'(wr_count), 4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
Write-side pointer and status block of the dual-clock FIFO, in the write clock domain. Keeps the binary write pointer, publishes its Gray-coded form for synchronisation into the read domain, and computes full, almost-full, fill level and overflow from the read pointer after it is synchronised into this domain. The Gray pointer feeds the read-domain synchroniser. The synchronised read Gray pointer arrives on this block's input.

Parameters:
AW, 4, address width; FIFO depth = 2**AW; pointers are AW+1 bits; legal range AW >= 2
AFULL_GAP, 2, almost_full asserts when free entries <= AFULL_GAP; legal range 0..2**AW-1

Ports:
clk  input  1  write-domain clock
reset  input  1  asynchronous active-high reset
wr_en  input  1  write request, sampled on rising clk
rptr_gray_sync  input  AW+1  read pointer, Gray coded, already synchronised to clk
wr_addr  output  AW  RAM write address (low AW bits of binary write pointer)
wptr_gray  output  AW+1  registered Gray-coded write pointer, sent to read domain
full  output  1  FIFO full; writes are refused
almost_full  output  1  free entries <= AFULL_GAP
wr_count  output  AW+1  entries occupied as seen from write domain, 0..2**AW
overflow  output  1  one-cycle pulse: wr_en was high while full

Behaviour:
- Reset (asynchronous assert, release synchronous to clk): wbin=0, wptr_gray=0, wr_addr=0, full=0, almost_full=0, wr_count=0, overflow=0.
- accept = wr_en & ~full, using the registered full.
- wbin_next = wbin + accept (mod 2**(AW+1)). wgray_next = bin2gray(wbin_next).
- All outputs are registered. Each output updates on the same edge that advances wbin. wr_addr = wbin[AW-1:0].
- rbin = gray2bin(rptr_gray_sync). This path is combinational from the input.
- full <= (wgray_next == {~rptr_gray_sync[AW:AW-1], rptr_gray_sync[AW-2:0]}).
- full asserts on the same edge as the write that fills the last entry. No extra write is ever accepted.
- full deasserts on the first edge after rptr_gray_sync advances.
- wr_count <= wbin_next - rbin (mod 2**(AW+1)). The result never exceeds 2**AW.
- almost_full <= (2**AW - (wbin_next - rbin)) <= AFULL_GAP.
- overflow <= wr_en & full. The pointer is unchanged on a refused write. overflow is not sticky.
- Wrap-around: wbin rolls from 2**(AW+1)-1 to 0. wptr_gray changes exactly one bit per accepted write, including across the wrap.
- Simultaneous write and read-pointer advance: both take effect in the same evaluation. For example, at full with wr_en=1 and the read pointer advancing in that cycle, the write is refused (registered full=1) and full clears on that edge.
- rptr_gray_sync may jump several counts per cycle, because it is a slow-domain sample. All status outputs remain correct for any jump that does not pass the write pointer.
- Reset mid-operation: all state returns to reset values immediately. The read domain must be reset in the same reset event.

Decomposition:
- Shared package holds the pointer-width constant function (AW+1) and the full-compare helper. The same compare is reused by the read-side empty block.
- Reuse the existing bin2gray for wgray_next with DW=AW+1.
- Add one new sub-module, gray2bin (DW parameter; bin[DW-1]=gray[DW-1], bin[i]=bin[i+1]^gray[i]). It is instantiated for rptr_gray_sync and is shared with the read side.

Test Plan:
- AW=3, reset held then released, wr_en=0 -> all outputs 0 for 5 cycles; wptr_gray stable at 0000.
- AW=3, rptr_gray_sync=0000, 8 consecutive wr_en:
  - wr_addr steps 0..7.
  - wptr_gray steps 0001,0011,0010,0110,0111,0101,0100,1100.
  - almost_full (AFULL_GAP=2) rises on the edge giving wr_count=6.
  - full rises on the edge giving wr_count=8.
- Full state, wr_en=1 for 3 cycles -> wbin and wptr_gray unchanged, overflow=1 for each of those 3 cycles, then 0.
- Full state, rptr_gray_sync jumps 0000 -> 0010 (binary 3) -> next edge: full=0, wr_count=5, almost_full=0; a following single write gives wr_count=6 and almost_full=1.
- Continuous writes with the read pointer tracking 2 behind for 40 cycles:
  - wptr_gray wraps 1000 -> 0000.
  - Every transition flips exactly one bit (bench checks popcount of XOR == 1).
  - full never asserts.
- Reset asserted mid-stream at wr_count=5 -> all outputs 0 immediately, before the next clk edge; operation resumes correctly after release.
